// File: rtl/gf_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gf_sel_pkg
// Purpose  : Shared constants for the track-selection stage: output word tags,
//            field offsets of the track and trailer word formats, counter
//            widths and a saturating-increment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gf_sel_pkg;

  localparam int WORD_W = 32;
  localparam int Q_W    = 3;
  localparam int CNT_W  = 12;
  localparam int EVT_W  = 6;

  localparam logic [1:0] TAG_TRACK   = 2'b01;
  localparam logic [1:0] TAG_TRAILER = 2'b11;

  // Common tag position
  localparam int TAG_LSB     = 30;

  // Track word: [31:30] tag, [29:27] quality, [26:16] track id, [15:0] chi2
  localparam int TRK_Q_LSB   = 27;
  localparam int TRK_ID_LSB  = 16;
  localparam int TRK_CHI_LSB = 0;

  // Trailer word: [31:30] tag, [29:24] event count, [23:12] accepts, [11:0] rejects
  localparam int TRL_EVT_LSB = 24;
  localparam int TRL_ACC_LSB = 12;
  localparam int TRL_REJ_LSB = 0;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : gf_sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO. The head word is
//            visible on o_data whenever o_empty is low. A push and a pop in
//            the same cycle are both honoured, even when full, because the
//            pop frees the slot the push lands in. A push into a full FIFO
//            without a pop is discarded (the caller flags it).
// Ports    : clock, reset_n        - clock, async active-low reset
//            i_push, i_data        - write strobe and word
//            i_pop                 - consume head word (ignored when empty)
//            o_data                - head word (zero while empty)
//            o_full, o_empty       - occupancy status
//            o_count               - occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module gf_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full   = (r_count == C_FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = o_empty ? '0 : r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage is not reset; o_data is masked while empty instead.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/comp_track_select.sv
`default_nettype none
// ============================================================================
// Module   : comp_track_select
// Purpose  : Applies the chi2 cut and overflow veto to delay-aligned fitted
//            tracks, packs accepted tracks into 32-bit words, appends a
//            per-event trailer with accept/reject counts, and buffers the
//            result in an FWFT FIFO with an advisory hold to the fitter.
// Ports    : clock, reset_n              - clock, async active-low reset
//            in_valid, in_eoe            - beat strobe, end-of-event qualifier
//            in_quality, in_chi2,
//            in_track_id                 - track fields
//            chi_cut                     - static chi2 threshold
//            out_valid, out_ready,
//            out_data                    - output handshake and head word
//            hold                        - back-pressure advisory
//            overflow_err                - sticky FIFO overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module comp_track_select
  import gf_sel_pkg::*;
#(
  parameter int CHI_W       = 16,
  parameter int ID_W        = 11,
  parameter int DEPTH       = 16,
  parameter int HOLD_MARGIN = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_eoe,
  input  logic [Q_W-1:0]   in_quality,
  input  logic [CHI_W-1:0] in_chi2,
  input  logic [ID_W-1:0]  in_track_id,
  input  logic [CHI_W-1:0] chi_cut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             hold,
  output logic             overflow_err
);

  localparam int               C_CNT_BITS   = $clog2(DEPTH) + 1;
  localparam logic [C_CNT_BITS-1:0] C_HOLD_LEVEL = C_CNT_BITS'(DEPTH - HOLD_MARGIN);

  // Stage 1 input registers
  logic             r_s1_valid;
  logic             r_s1_eoe;
  logic [Q_W-1:0]   r_s1_quality;
  logic [CHI_W-1:0] r_s1_chi2;
  logic [ID_W-1:0]  r_s1_id;

  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_rej_cnt;
  logic [EVT_W-1:0] r_evt_cnt;
  logic             r_hold;
  logic             r_overflow_err;

  logic                  w_accept;
  logic                  w_push;
  logic [WORD_W-1:0]     w_word;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [C_CNT_BITS-1:0] w_fifo_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_eoe     <= 1'b0;
      r_s1_quality <= '0;
      r_s1_chi2    <= '0;
      r_s1_id      <= '0;
    end else begin
      r_s1_valid   <= in_valid;
      r_s1_eoe     <= in_eoe;
      r_s1_quality <= in_quality;
      r_s1_chi2    <= in_chi2;
      r_s1_id      <= in_track_id;
    end
  end

  // Any overflow flag vetoes the track regardless of chi2.
  assign w_accept = (r_s1_quality == '0) && (r_s1_chi2 <= chi_cut);

  // Trailer uses the counter values before this beat's update, which hold
  // every track of the event since track beats update them one cycle earlier.
  always_comb begin
    w_word = '0;
    if (r_s1_eoe) begin
      w_word = {TAG_TRAILER, r_evt_cnt, r_acc_cnt, r_rej_cnt};
    end else begin
      w_word = {TAG_TRACK, r_s1_quality, r_s1_id, r_s1_chi2};
    end
  end

  assign w_push = r_s1_valid & (r_s1_eoe | w_accept);
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_cnt <= '0;
      r_rej_cnt <= '0;
      r_evt_cnt <= '0;
    end else if (r_s1_valid) begin
      if (r_s1_eoe) begin
        r_acc_cnt <= '0;
        r_rej_cnt <= '0;
        r_evt_cnt <= r_evt_cnt + 1'b1;
      end else if (w_accept) begin
        r_acc_cnt <= sat_inc(r_acc_cnt);
      end else begin
        r_rej_cnt <= sat_inc(r_rej_cnt);
      end
    end
  end

  gf_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign out_valid = ~w_fifo_empty;

  // A write into a full FIFO is only lost when no pop frees a slot that cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold         <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_hold <= (w_fifo_count >= C_HOLD_LEVEL);
      if (w_push & w_fifo_full & ~w_pop) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

  assign hold         = r_hold;
  assign overflow_err = r_overflow_err;

endmodule
`default_nettype wire

// File: tb/tb_comp_track_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_comp_track_select
// Purpose  : Self-checking bench for comp_track_select. Stimulus tasks feed a
//            behavioural event model that queues the expected output words;
//            an independent monitor pops and compares on every handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comp_track_select;

  localparam int CHI_W = 16;
  localparam int ID_W  = 11;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_eoe = 1'b0;
  logic [2:0]       in_quality = '0;
  logic [CHI_W-1:0] in_chi2 = '0;
  logic [ID_W-1:0]  in_track_id = '0;
  logic [CHI_W-1:0] chi_cut = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic             hold;
  logic             overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Event model state
  logic [31:0] exp_q[$];
  int m_acc = 0;
  int m_rej = 0;
  int m_evt = 0;

  comp_track_select #(
    .CHI_W(CHI_W), .ID_W(ID_W), .DEPTH(16), .HOLD_MARGIN(4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_eoe       (in_eoe),
    .in_quality   (in_quality),
    .in_chi2      (in_chi2),
    .in_track_id  (in_track_id),
    .chi_cut      (chi_cut),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .hold         (hold),
    .overflow_err (overflow_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  function automatic logic [31:0] track_word(input int q, input int id, input int chi);
    longint w;
    w = 64'h4000_0000 + longint'(q) * (1 << 27) + longint'(id) * (1 << 16) + longint'(chi);
    return w[31:0];
  endfunction

  function automatic logic [31:0] trailer_word(input int evt, input int acc, input int rej);
    longint w;
    w = 64'hC000_0000 + longint'(evt % 64) * (1 << 24) + longint'(sat(acc)) * (1 << 12)
        + longint'(sat(rej));
    return w[31:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // dropped=1 marks a word the FIFO cannot hold; it still counts as accepted.
  task automatic send_track(input int q, input int id, input int chi, input bit dropped = 1'b0);
    if (q == 0 && chi <= int'(chi_cut)) begin
      if (!dropped) exp_q.push_back(track_word(q, id, chi));
      m_acc++;
    end else begin
      m_rej++;
    end
    in_valid    = 1'b1;
    in_eoe      = 1'b0;
    in_quality  = 3'(q);
    in_track_id = ID_W'(id);
    in_chi2     = CHI_W'(chi);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_eoe();
    exp_q.push_back(trailer_word(m_evt, m_acc, m_rej));
    m_acc = 0;
    m_rej = 0;
    m_evt++;
    in_valid    = 1'b1;
    in_eoe      = 1'b1;
    in_quality  = 3'($urandom);
    in_chi2     = CHI_W'($urandom);
    in_track_id = ID_W'($urandom);
    tick();
    in_valid = 1'b0;
    in_eoe   = 1'b0;
  endtask

  task automatic drain();
    int budget;
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      tick();
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words still expected, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
    check("drain_empty", 32'(out_valid), 32'd0);
  endtask

  // Monitor: compares every word the DUT hands over against the model queue.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%08h, expected no word", out_data);
      end else begin
        check("fifo_word", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_overflow", 32'(overflow_err), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic cut/veto event with latency check
    chi_cut   = 16'd100;
    out_ready = 1'b0;
    send_track(0, 'h123, 100);
    check("latency_n1", 32'(out_valid), 32'd0);
    tick();
    check("latency_n2", 32'(out_valid), 32'd1);
    check("first_word", out_data, 32'h4123_0064);
    send_track(0, 'h055, 101);
    send_track(1, 'h7ff, 5);
    send_eoe();
    send_eoe();
    drain();

    // Event counter wrap
    for (int i = 0; i < 64; i++) begin
      out_ready = 1'b1;
      send_eoe();
    end
    drain();

    // Hold threshold, full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_track(0, $urandom_range(0, 2047), $urandom_range(0, 100));
    repeat (4) tick();
    check("hold_at_11", 32'(hold), 32'd0);
    send_track(0, $urandom_range(0, 2047), $urandom_range(0, 100));
    repeat (4) tick();
    check("hold_at_12", 32'(hold), 32'd1);
    for (int i = 0; i < 4; i++) send_track(0, $urandom_range(0, 2047), $urandom_range(0, 100));
    repeat (4) tick();
    check("count_full", 32'(dut.u_fifo.o_count), 32'd16);
    send_track(0, 'h2aa, 77);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    check("count_push_pop", 32'(dut.u_fifo.o_count), 32'd16);
    check("no_overflow_push_pop", 32'(overflow_err), 32'd0);
    drain();

    // Overflow: 17th word dropped, first 16 intact
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_track(0, i, i);
    send_track(0, 'h3ff, 99, 1'b1);
    repeat (4) tick();
    check("overflow_set", 32'(overflow_err), 32'd1);
    drain();
    check("overflow_sticky", 32'(overflow_err), 32'd1);

    // Reject counter saturation
    out_ready = 1'b1;
    for (int i = 0; i < 4100; i++) begin
      if (i % 2 == 0) send_track($urandom_range(1, 7), i % 2048, $urandom_range(0, 100));
      else            send_track(0, i % 2048, $urandom_range(101, 65535));
    end
    send_eoe();
    drain();

    // Asynchronous reset mid-event
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_track(0, 'h100 + i, 50);
    repeat (3) tick();
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_overflow", 32'(overflow_err), 32'd0);
    exp_q.delete();
    m_acc = 0;
    m_rej = 0;
    m_evt = 0;
    tick();
    reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send_eoe();
    drain();

    // Randomized traffic respecting hold
    chi_cut = CHI_W'($urandom_range(100, 60000));
    for (int n = 0; n < 600; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0) begin
          send_eoe();
        end else begin
          int c;
          int q;
          c = int'(chi_cut) + int'($urandom_range(0, 100)) - 50;
          if (c < 0) c = 0;
          if (c > 65535) c = 65535;
          q = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
          send_track(q, $urandom_range(0, 2047), c);
        end
      end else begin
        tick();
      end
    end
    send_eoe();
    drain();
    check("random_no_overflow", 32'(overflow_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/comp_track_select.md
# comp_track_select

Track-selection stage directly downstream of the quality-flag delay line in the fitter pipeline. It takes each fitted track's chi2 together with its 3-bit quality flags, already delay-aligned to the same beat, and applies the chi2 cut and the overflow veto. Accepted tracks are packed into 32-bit output words, and a per-event trailer word with accept/reject counts is appended. Output is buffered in a 16-deep FIFO with a valid/ready handshake and an advisory hold back to the fitter.

## Interface
- CHI_W, 16, chi2 width
- ID_W, 11, track id width
- DEPTH, 16, output FIFO depth (power of 2)
- HOLD_MARGIN, 4, hold asserts when occupancy >= DEPTH-HOLD_MARGIN
- clock  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat strobe
- in_eoe  in  1  qualifies beat as end-of-event (track fields ignored)
- in_quality  in  3  delay-aligned flags: [0] chi overflow, [1] param overflow, [2] hit-coord overflow
- in_chi2  in  CHI_W  fitted chi2
- in_track_id  in  ID_W  track identifier
- chi_cut  in  CHI_W  static chi2 threshold (changes only between runs)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accept
- out_data  out  32  FIFO head word
- hold  out  1  back-pressure to fitter
- overflow_err  out  1  sticky FIFO-overflow flag

## Operation
- Track beat (in_valid=1, in_eoe=0):
  - Accept iff in_quality==3'b000 and in_chi2 <= chi_cut (unsigned).
  - Accepted track written to FIFO: [31:30]=2'b01, [29:27]=quality, [26:16]=track_id, [15:0]=chi2.
  - Rejected track is not written.
  - acc_cnt or rej_cnt increments. Both are 12-bit and saturate at 4095.
- EOE beat (in_valid=1, in_eoe=1):
  - Trailer written: [31:30]=2'b11, [29:24]=evt_cnt[5:0], [23:12]=acc_cnt, [11:0]=rej_cnt.
  - Counts used are those including every track beat preceding the EOE beat.
  - acc_cnt and rej_cnt then clear to 0. evt_cnt (6-bit) increments and wraps 63→0.
  - An empty event yields a trailer with zero counts.
- At most one FIFO write per cycle. A track beat and an EOE are never on the same beat.
- FIFO is first-word-fall-through. A pop occurs on out_valid & out_ready. A push and a pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot).
- Write to a full FIFO with no simultaneous pop: word dropped, overflow_err set. overflow_err clears only on reset.
- Input beats are always consumed. hold is advisory only.
- Reset mid-event: FIFO flushed, all counters 0, partial event lost, no trailer emitted.

## Timing
- Stage 1: inputs registered, compare and word packing done.
- Stage 2: FIFO write.
- Beat at cycle N with FIFO empty → out_valid=1 with that word in cycle N+2. Latency is 2.
- hold is registered from occupancy. Upstream may still deliver up to 2 beats after hold rises; HOLD_MARGIN=4 covers this.
- Reset values:
  - out_valid=0, out_data=0, hold=0, overflow_err=0
  - acc_cnt=rej_cnt=evt_cnt=0
  - FIFO read/write pointers 0, pipeline valid 0

## Structure
- Shared package gf_sel_pkg holds:
  - tag constants TAG_TRACK=2'b01, TAG_TRAILER=2'b11
  - field widths/offsets of both word formats
  - CNT_W=12, EVT_W=6
- One sub-module: gf_sync_fifo, a parameterised FWFT FIFO providing count, full and empty, with DEPTH+1-wide occupancy.
- Selection, counters, packing and hold logic stay in the top level.

## Test plan
- chi_cut=100: tracks chi2=100, q=0 / chi2=101, q=0 / chi2=5, q=3'b001, then EOE → one word 0x4?xx0064 (id-dependent); trailer acc=1, rej=2, evt=0.
- Two consecutive EOE beats → trailers evt=0 counts(…) then evt=1 acc=0 rej=0. Wrap check: 64 events → evt field returns to 0.
- out_ready=0, 12 accepted tracks → hold=1 once occupancy reaches 12. 17th write with no pop → overflow_err=1, word lost, first 16 words intact in order.
- FIFO full with out_ready=1 and a simultaneous write → no drop, occupancy stays 16, overflow_err stays 0.
- 4100 rejected tracks then EOE → rej field 4095 (saturated).
- Assert reset_n low mid-event after 3 accepts → out_valid=0 asynchronously. After release, next EOE gives a trailer with acc=0, evt=0.
